ov_pixel_capture: RTL

Front-end capture stage for the OV7670 parallel bus. Samples VSYNC/HREF/D[7:0] on ov_pclk and pairs bytes into 16-bit YUV422 words. Produces pixel_valid strobes with pixel coordinates, plus frame_start/frame_done pulses. Checks frame geometry and feeds the camera_ctrl key-detection stage directly.

---
 rtl/ov_cam_pkg.sv | 30 +++
 rtl/ov_byte_pairer.sv | 52 +++++
 rtl/ov_pixel_capture.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ov_cam_pkg.sv
// Shared definitions for the OV7670 capture path: geometry defaults,
// capture FSM encoding and coordinate widths.
package ov_cam_pkg;

  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;
  localparam int X_W            = 10;
  localparam int Y_W            = 9;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } cap_state_e;

  function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
    logic [X_W-1:0] r;
    if (v == {X_W{1'b1}}) r = v;
    else                  r = v + 10'd1;
    return r;
  endfunction

  function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
    logic [Y_W-1:0] r;
    if (v == {Y_W{1'b1}}) r = v;
    else                  r = v + 9'd1;
    return r;
  endfunction

endpackage

// File: rtl/ov_byte_pairer.sv
// Line-local byte pairing: latches the high byte, flags the completing byte
// and counts pairs; reports a dangling odd byte when the line closes.
module ov_byte_pairer
  import ov_cam_pkg::*;
(
  input  logic           ov_pclk,
  input  logic           rst,
  input  logic           hs_q,
  input  logic [7:0]     d_q,
  input  logic           line_start,
  input  logic           line_end,
  output logic           pair_valid,
  output logic [15:0]    pair_data,
  output logic [X_W-1:0] pair_cnt,
  output logic           odd_err
);

  logic           phase_r;
  logic [7:0]     hi_r;
  logic [X_W-1:0] cnt_r;

  // pair phase, high-byte latch and per-line pair counter
  always_ff @(posedge ov_pclk or negedge rst) begin
    if (!rst) begin
      phase_r <= 1'b0;
      hi_r    <= 8'd0;
      cnt_r   <= 10'd0;
    end else if (line_start) begin
      phase_r <= 1'b1;
      hi_r    <= d_q;
      cnt_r   <= 10'd0;
    end else if (line_end) begin
      phase_r <= 1'b0;
      cnt_r   <= 10'd0;
    end else if (hs_q) begin
      if (phase_r) begin
        phase_r <= 1'b0;
        cnt_r   <= sat_inc_x(cnt_r);
      end else begin
        phase_r <= 1'b1;
        hi_r    <= d_q;
      end
    end
  end

  // the counter still holds this line's total during the line_end cycle
  assign pair_valid = hs_q && phase_r && !line_start && !line_end;
  assign pair_data  = {hi_r, d_q};
  assign pair_cnt   = cnt_r;
  assign odd_err    = line_end && phase_r;

endmodule

// File: rtl/ov_pixel_capture.sv
// OV7670 parallel-bus capture: frame sync FSM, frame skipping, geometry
// checking and registered pixel/frame strobes.
module ov_pixel_capture
  import ov_cam_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int FRAME_SKIP = 0
)
(
  input  logic           ov_pclk,
  input  logic           rst,
  input  logic           ov_vs,
  input  logic           ov_hs,
  input  logic [7:0]     cam_data,
  input  logic           capture_en,
  output logic [15:0]    pixel_data,
  output logic           pixel_valid,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           frame_start,
  output logic           frame_done,
  output logic           frame_err,
  output logic [15:0]    frame_cnt
);

  localparam logic [X_W-1:0] WIDTH_C  = X_W'(IMG_WIDTH);
  localparam logic [Y_W-1:0] HEIGHT_C = Y_W'(IMG_HEIGHT);
  localparam logic [7:0]     SKIP_C   = 8'(FRAME_SKIP);

  logic       vs_r, hs_r, vs_p_r, hs_p_r;
  logic [7:0] d_r;
  cap_state_e state_r, next_state_s;
  logic [7:0]     skip_r;
  logic           keep_r, line_err_r;
  logic [Y_W-1:0] y_r;

  logic           vs_rise_s, vs_fall_s, line_start_s, line_end_s;
  logic           pair_valid_s, odd_err_s;
  logic [15:0]    pair_data_s;
  logic [X_W-1:0] pair_cnt_s;
  logic           start_evt_s, end_evt_s, act_line_end_s, keep_now_s;
  logic           line_bad_s, err_next_s, pix_ok_s;
  logic [Y_W-1:0] y_next_s;

  // single input register stage plus one cycle of history for edge detect
  always_ff @(posedge ov_pclk or negedge rst) begin
    if (!rst) begin
      vs_r   <= 1'b0;
      hs_r   <= 1'b0;
      d_r    <= 8'd0;
      vs_p_r <= 1'b0;
      hs_p_r <= 1'b0;
    end else begin
      vs_r   <= ov_vs;
      hs_r   <= ov_hs;
      d_r    <= cam_data;
      vs_p_r <= vs_r;
      hs_p_r <= hs_r;
    end
  end

  assign vs_rise_s    = vs_r & ~vs_p_r;
  assign vs_fall_s    = ~vs_r & vs_p_r;
  assign line_start_s = hs_r & ~hs_p_r;
  // HREF still high at the VSYNC edge closes the line in the same cycle
  assign line_end_s   = (~hs_r & hs_p_r) | (vs_rise_s & hs_r);

  ov_byte_pairer u_pairer (
    .ov_pclk    (ov_pclk),
    .rst        (rst),
    .hs_q       (hs_r),
    .d_q        (d_r),
    .line_start (line_start_s),
    .line_end   (line_end_s),
    .pair_valid (pair_valid_s),
    .pair_data  (pair_data_s),
    .pair_cnt   (pair_cnt_s),
    .odd_err    (odd_err_s)
  );

  // FSM state register
  always_ff @(posedge ov_pclk or negedge rst) begin
    if (!rst) state_r <= ST_SYNC;
    else      state_r <= next_state_s;
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_SYNC:   if (vs_rise_s) next_state_s = ST_BLANK;  else next_state_s = ST_SYNC;
      ST_BLANK:  if (vs_fall_s) next_state_s = ST_ACTIVE; else next_state_s = ST_BLANK;
      ST_ACTIVE: if (vs_rise_s) next_state_s = ST_BLANK;  else next_state_s = ST_ACTIVE;
      default:   next_state_s = ST_SYNC;
    endcase
  end

  // FSM output decode: frame events, line bookkeeping and pixel qualification
  always_comb begin
    start_evt_s    = 1'b0;
    end_evt_s      = 1'b0;
    act_line_end_s = 1'b0;
    case (state_r)
      ST_BLANK:  start_evt_s = vs_fall_s;
      ST_ACTIVE: begin
        end_evt_s      = vs_rise_s;
        act_line_end_s = line_end_s;
      end
      default:   start_evt_s = 1'b0;
    endcase
    keep_now_s = capture_en && (skip_r == 8'd0);
    line_bad_s = odd_err_s || (pair_cnt_s != WIDTH_C);
    if (act_line_end_s) begin
      y_next_s   = sat_inc_y(y_r);
      err_next_s = line_err_r | line_bad_s;
    end else begin
      y_next_s   = y_r;
      err_next_s = line_err_r;
    end
    pix_ok_s = (state_r == ST_ACTIVE) && keep_r && pair_valid_s && !end_evt_s &&
               (pair_cnt_s < WIDTH_C) && (y_r < HEIGHT_C);
  end

  // per-frame bookkeeping: keep decision, skip countdown, line count, sticky error
  always_ff @(posedge ov_pclk or negedge rst) begin
    if (!rst) begin
      keep_r     <= 1'b0;
      skip_r     <= 8'd0;
      line_err_r <= 1'b0;
      y_r        <= 9'd0;
    end else if (start_evt_s) begin
      keep_r     <= keep_now_s;
      line_err_r <= 1'b0;
      y_r        <= 9'd0;
      if (capture_en) skip_r <= keep_now_s ? SKIP_C : (skip_r - 8'd1);
    end else if (state_r == ST_ACTIVE) begin
      line_err_r <= err_next_s;
      y_r        <= y_next_s;
    end
  end

  // registered pixel and frame outputs
  always_ff @(posedge ov_pclk or negedge rst) begin
    if (!rst) begin
      pixel_valid <= 1'b0;
      pixel_data  <= 16'd0;
      pixel_x     <= 10'd0;
      pixel_y     <= 9'd0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      pixel_valid <= pix_ok_s;
      if (pix_ok_s) begin
        pixel_data <= pair_data_s;
        pixel_x    <= pair_cnt_s;
        pixel_y    <= y_r;
      end
      frame_start <= start_evt_s & keep_now_s;
      frame_done  <= end_evt_s & keep_r;
      frame_err   <= end_evt_s & keep_r & (err_next_s | (y_next_s != HEIGHT_C));
      if (end_evt_s & keep_r) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
